// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer.
// Default frame geometry and the state encoding used by the top FSM.
package cnn_pkg;

    localparam int CNN_H         = 24;
    localparam int CNN_W         = 24;
    localparam int CNN_DATA_BITS = 8;
    localparam int CNN_N_CLASS   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PUSH,
        S_GAP,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cnn_argmax_seq.sv
// Sequential signed argmax, one class per cycle after start.
// Ties keep the lowest index because only a strictly greater score replaces.
module cnn_argmax_seq
    import cnn_pkg::*;
#(
    parameter int N_CLASS   = CNN_N_CLASS,
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int IDX_BITS  = clog2(CNN_N_CLASS)
) (
    input  logic                           clk,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [N_CLASS*DATA_BITS-1:0]   scores_i,
    output logic                           done_o,
    output logic [IDX_BITS-1:0]            idx_o,
    output logic [DATA_BITS-1:0]           max_o
);

    logic [N_CLASS*DATA_BITS-1:0] vec_q;
    logic signed [DATA_BITS-1:0]  best_q;
    logic signed [DATA_BITS-1:0]  cand;
    logic [IDX_BITS-1:0]          idx_q;
    logic [IDX_BITS-1:0]          k_q;
    logic                         run_q;
    logic                         done_q;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (k_q == IDX_BITS'(i)) cand = vec_q[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            vec_q  <= '0;
            best_q <= '0;
            idx_q  <= '0;
            k_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                vec_q  <= scores_i;
                best_q <= scores_i[DATA_BITS-1:0];
                idx_q  <= '0;
                k_q    <= IDX_BITS'(1);
                run_q  <= 1'b1;
            end else if (run_q) begin
                if (cand > best_q) begin
                    best_q <= cand;
                    idx_q  <= k_q;
                end
                if (k_q == IDX_BITS'(N_CLASS - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign idx_o  = idx_q;
    assign max_o  = best_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Feeds one frame row by row into the line buffer, then waits for the
// dense result and reports the argmax class, score, done and timeout error.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int H         = CNN_H,
    parameter int W         = CNN_W,
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int N_CLASS   = CNN_N_CLASS,
    parameter int ADDR_BITS = clog2(CNN_H),
    parameter int ROW_GAP   = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                         clk,
    input  logic                         rstn_i,
    input  logic                         start_i,
    output logic                         mem_rd_o,
    output logic [ADDR_BITS-1:0]         mem_addr_o,
    input  logic [W*DATA_BITS-1:0]       mem_rdata_i,
    output logic [W*DATA_BITS-1:0]       row_data_o,
    output logic                         row_valid_o,
    input  logic                         row_ready_i,
    input  logic                         res_valid_i,
    input  logic [N_CLASS*DATA_BITS-1:0] res_data_i,
    output logic [2:0]                   class_o,
    output logic [DATA_BITS-1:0]         score_o,
    output logic                         done_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int GW = (ROW_GAP < 2) ? 1 : clog2(ROW_GAP);
    localparam int WW = clog2(TIMEOUT + 1);

    state_e                   state_q;
    logic [ADDR_BITS-1:0]     row_q;
    logic [GW-1:0]            gap_q;
    logic [WW-1:0]            wd_q;
    logic                     mem_rd_q;
    logic [W*DATA_BITS-1:0]   row_data_q;
    logic                     row_valid_q;
    logic [2:0]               class_q;
    logic [DATA_BITS-1:0]     score_q;
    logic                     done_q;
    logic                     err_q;

    logic                     arg_start;
    logic                     arg_done;
    logic [2:0]               arg_idx;
    logic [DATA_BITS-1:0]     arg_max;

    // The argmax unit latches the score vector itself on this strobe.
    assign arg_start = (state_q == S_WAIT) && res_valid_i;

    cnn_argmax_seq #(
        .N_CLASS   (N_CLASS),
        .DATA_BITS (DATA_BITS),
        .IDX_BITS  (3)
    ) u_argmax (
        .clk      (clk),
        .rst_i    (rstn_i),
        .start_i  (arg_start),
        .scores_i (res_data_i),
        .done_o   (arg_done),
        .idx_o    (arg_idx),
        .max_o    (arg_max)
    );

    always_ff @(posedge clk or posedge rstn_i) begin
        if (rstn_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            gap_q       <= '0;
            wd_q        <= '0;
            mem_rd_q    <= 1'b0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            class_q     <= '0;
            score_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_rd_q    <= 1'b0;
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q  <= S_FETCH;
                        row_q    <= '0;
                        err_q    <= 1'b0;
                        mem_rd_q <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    row_data_q <= mem_rdata_i;
                    state_q    <= S_PUSH;
                end
                S_PUSH: begin
                    if (row_ready_i) begin
                        row_valid_q <= 1'b1;
                        if (row_q == ADDR_BITS'(H - 1)) begin
                            state_q <= S_WAIT;
                            wd_q    <= '0;
                        end else begin
                            row_q <= row_q + 1'b1;
                            if (ROW_GAP == 0) begin
                                state_q  <= S_FETCH;
                                mem_rd_q <= 1'b1;
                            end else begin
                                state_q <= S_GAP;
                                gap_q   <= GW'(ROW_GAP - 1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q  <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                // A result arriving on the timeout cycle still wins.
                S_WAIT: begin
                    if (res_valid_i) begin
                        wd_q    <= '0;
                        state_q <= S_ARGMAX;
                    end else if (wd_q == WW'(TIMEOUT)) begin
                        wd_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    if (arg_done) begin
                        class_q <= arg_idx;
                        score_q <= arg_max;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = row_q;
    assign row_data_o  = row_data_q;
    assign row_valid_o = row_valid_q;
    assign class_o     = class_q;
    assign score_o     = score_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: row issue, stall, argmax,
// timeout and mid-frame reset, with a small frame memory model.
module tb_cnn_frame_sequencer;

    localparam int H  = 24;
    localparam int W  = 24;
    localparam int DB = 8;
    localparam int NC = 7;
    localparam int AB = 5;
    localparam int RW = W * DB;
    localparam int SW = NC * DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic          res_valid = 1'b0;
    logic [RW-1:0] rdata = '0;
    logic [SW-1:0] res_data = '0;

    logic          mem_rd;
    logic [AB-1:0] mem_addr;
    logic [RW-1:0] row_data;
    logic          row_valid;
    logic [2:0]    class_o;
    logic [DB-1:0] score;
    logic          done;
    logic          busy;
    logic          err;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    int            npulse = 0;
    int            nrd = 0;
    int            ndone = 0;
    int            nerr = 0;
    int            done_cyc = 0;
    int            err_cyc = 0;
    logic          err_prev = 1'b0;
    int            pulse_cyc [256];
    logic [RW-1:0] pulse_data [256];
    int            rd_addr [256];

    cnn_frame_sequencer #(
        .H (H), .W (W), .DATA_BITS (DB), .N_CLASS (NC), .ADDR_BITS (AB),
        .ROW_GAP (4), .TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rstn_i      (rst),
        .start_i     (start),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (rdata),
        .row_data_o  (row_data),
        .row_valid_o (row_valid),
        .row_ready_i (ready),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .class_o     (class_o),
        .score_o     (score),
        .done_o      (done),
        .busy_o      (busy),
        .err_o       (err)
    );

    function automatic logic [RW-1:0] row_of(input int k);
        logic [RW-1:0] r;
        r = '0;
        for (int p = 0; p < W; p++) r[p*DB +: DB] = 8'(k * 29 + p * 7 + 3);
        return r;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd) rdata <= row_of(int'(mem_addr));

    always @(negedge clk) begin
        if (row_valid && npulse < 256) begin
            pulse_cyc[npulse]  <= cyc;
            pulse_data[npulse] <= row_data;
            npulse <= npulse + 1;
        end
        if (mem_rd && nrd < 256) begin
            rd_addr[nrd] <= int'(mem_addr);
            nrd <= nrd + 1;
        end
        if (done) begin
            ndone    <= ndone + 1;
            done_cyc <= cyc;
        end
        if (err && !err_prev) begin
            nerr    <= nerr + 1;
            err_cyc <= cyc;
        end
        err_prev <= err;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_result(input logic [SW-1:0] v, output int c0);
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_data  = v;
        c0 = cyc;
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        for (int i = 0; i < budget && npulse < target; i++) step();
    endtask

    task automatic test_reset();
        logic [RW+DB+AB+9:0] outs;
        rst = 1'b1;
        step();
        step();
        outs = {mem_rd, mem_addr, row_data, row_valid, class_o, score, done, busy, err};
        ntot++;
        if (outs !== '0) $display("FAIL reset_outs: got %0h want 0", outs);
        else npass++;
        rst = 1'b0;
        step();
        step();
        step();
        ntot++;
        if ({busy, mem_rd, row_valid} !== 3'b000)
            $display("FAIL idle_after_reset: got %b want 000", {busy, mem_rd, row_valid});
        else npass++;
    endtask

    task automatic test_frame();
        int p0, r0, bad_addr, bad_gap, bad_data;
        p0 = npulse;
        r0 = nrd;
        ready = 1'b1;
        pulse_start();
        wait_pulses(p0 + 24, 400);
        ntot++;
        if (npulse - p0 !== 24) $display("FAIL frame_pulses: got %0d want 24", npulse - p0);
        else npass++;
        bad_addr = 0;
        bad_gap = 0;
        bad_data = 0;
        for (int k = 0; k < 24; k++) begin
            if (rd_addr[r0+k] != k) bad_addr++;
            if (pulse_data[p0+k] !== row_of(k)) bad_data++;
            if (k > 0 && pulse_cyc[p0+k] - pulse_cyc[p0+k-1] != 7) bad_gap++;
        end
        ntot++;
        if (bad_addr != 0 || nrd - r0 != 24)
            $display("FAIL frame_addr: got %0d bad of %0d reads want 0 bad of 24", bad_addr, nrd - r0);
        else npass++;
        ntot++;
        if (bad_gap != 0) $display("FAIL frame_spacing: got %0d bad gaps want 0", bad_gap);
        else npass++;
        ntot++;
        if (bad_data != 0) $display("FAIL frame_data: got %0d bad rows want 0", bad_data);
        else npass++;
    endtask

    task automatic test_argmax_mixed();
        logic [DB-1:0] s [NC];
        logic [SW-1:0] v;
        int c0, d0;
        s = '{8'hFD, 8'd12, 8'd40, 8'd40, 8'h80, 8'd7, 8'd0};
        for (int k = 0; k < NC; k++) v[k*DB +: DB] = s[k];
        d0 = ndone;
        send_result(v, c0);
        for (int i = 0; i < 30 && ndone == d0; i++) step();
        ntot++;
        if (ndone - d0 !== 1 || done_cyc - c0 !== 8)
            $display("FAIL mixed_latency: got %0d cycles want 8", done_cyc - c0);
        else npass++;
        ntot++;
        if (class_o !== 3'd2) $display("FAIL mixed_class: got %0d want 2", class_o);
        else npass++;
        ntot++;
        if (score !== 8'd40) $display("FAIL mixed_score: got %0h want 28", score);
        else npass++;
        step();
        ntot++;
        if ({done, busy} !== 2'b00) $display("FAIL mixed_done_width: got %b want 00", {done, busy});
        else npass++;
    endtask

    task automatic test_stall();
        int p0, d0, bad;
        p0 = npulse;
        d0 = ndone;
        pulse_start();
        wait_pulses(p0 + 5, 100);
        ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        @(posedge clk);
        #1 res_valid = 1'b1;
        @(posedge clk);
        #1 res_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        ntot++;
        if (npulse - p0 !== 5 || busy !== 1'b1)
            $display("FAIL stall_hold: got %0d pulses busy %b want 5 busy 1", npulse - p0, busy);
        else npass++;
        ntot++;
        if (row_data !== row_of(5)) $display("FAIL stall_data: got %0h want %0h", row_data, row_of(5));
        else npass++;
        ready = 1'b1;
        wait_pulses(p0 + 24, 400);
        bad = 0;
        for (int k = 0; k < 24; k++) if (pulse_data[p0+k] !== row_of(k)) bad++;
        ntot++;
        if (npulse - p0 !== 24 || bad != 0)
            $display("FAIL stall_frame: got %0d pulses %0d bad want 24 pulses 0 bad", npulse - p0, bad);
        else npass++;
        ntot++;
        if (ndone !== d0) $display("FAIL stale_result: got %0d dones want 0", ndone - d0);
        else npass++;
    endtask

    task automatic test_argmax_tie();
        logic [SW-1:0] v;
        int c0, d0, r0;
        for (int k = 0; k < NC; k++) v[k*DB +: DB] = 8'h80;
        d0 = ndone;
        r0 = nrd;
        send_result(v, c0);
        pulse_start();
        for (int i = 0; i < 30 && ndone == d0; i++) step();
        ntot++;
        if (ndone - d0 !== 1 || done_cyc - c0 !== 8)
            $display("FAIL tie_latency: got %0d cycles want 8", done_cyc - c0);
        else npass++;
        ntot++;
        if (class_o !== 3'd0 || score !== 8'h80)
            $display("FAIL tie_result: got class %0d score %0h want class 0 score 80", class_o, score);
        else npass++;
        for (int i = 0; i < 10; i++) step();
        ntot++;
        if (nrd !== r0 || busy !== 1'b0)
            $display("FAIL busy_start_ignored: got %0d reads busy %b want 0 reads busy 0", nrd - r0, busy);
        else npass++;
    endtask

    task automatic test_timeout();
        int p0, e0, d0;
        p0 = npulse;
        e0 = nerr;
        d0 = ndone;
        pulse_start();
        wait_pulses(p0 + 24, 400);
        for (int i = 0; i < 300 && nerr == e0; i++) step();
        ntot++;
        if (nerr - e0 !== 1 || err_cyc - pulse_cyc[p0+23] !== 101)
            $display("FAIL timeout_latency: got %0d cycles want 101", err_cyc - pulse_cyc[p0+23]);
        else npass++;
        ntot++;
        if (busy !== 1'b0 || ndone !== d0)
            $display("FAIL timeout_idle: got busy %b dones %0d want busy 0 dones 0", busy, ndone - d0);
        else npass++;
        for (int i = 0; i < 5; i++) step();
        ntot++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
        else npass++;
        pulse_start();
        ntot++;
        if ({err, busy} !== 2'b01) $display("FAIL err_clear: got %b want 01", {err, busy});
        else npass++;
    endtask

    task automatic test_reset_mid();
        logic [RW+DB+AB+9:0] outs;
        int r0, p0;
        r0 = nrd - 1;
        for (int i = 0; i < 200 && nrd < r0 + 11; i++) step();
        #2 rst = 1'b1;
        #1;
        outs = {mem_rd, mem_addr, row_data, row_valid, class_o, score, done, busy, err};
        ntot++;
        if (outs !== '0) $display("FAIL async_reset: got %0h want 0", outs);
        else npass++;
        step();
        rst = 1'b0;
        step();
        r0 = nrd;
        p0 = npulse;
        pulse_start();
        wait_pulses(p0 + 1, 50);
        ntot++;
        if (nrd - r0 < 1 || rd_addr[r0] !== 0)
            $display("FAIL restart_addr: got %0d want 0", rd_addr[r0]);
        else npass++;
        ntot++;
        if (npulse - p0 < 1 || pulse_data[p0] !== row_of(0))
            $display("FAIL restart_data: got %0h want %0h", pulse_data[p0], row_of(0));
        else npass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_argmax_mixed();
        test_stall();
        test_argmax_tie();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
